// File: rtl/sp_ram_be_clr.sv
// Single-port synchronous RAM with per-lane write enables, selectable
// read-during-write behaviour, optional output register and a clear sweep engine.
module sp_ram_be_clr #(
  parameter int Data_Width = 32,
  parameter int Addr_Width = 4,
  parameter int Lane_Width = 8,
  parameter int Rdw_Mode   = 0,
  parameter int Out_Reg    = 0,
  parameter logic [Data_Width-1:0] Init_Value = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  input  logic                             req,
  input  logic                             wr_rd_ena,
  input  logic [Addr_Width-1:0]            addr,
  input  logic [Data_Width/Lane_Width-1:0] byte_ena,
  input  logic [Data_Width-1:0]            Data_write,
  output logic [Data_Width-1:0]            Data_read,
  output logic                             rd_valid,
  output logic                             busy
);
  localparam int Lanes = Data_Width / Lane_Width;
  localparam int Depth = 1 << Addr_Width;

  if ((Data_Width % Lane_Width) != 0 || Rdw_Mode < 0 || Rdw_Mode > 2 ||
      Out_Reg < 0 || Out_Reg > 1) begin : g_param_check
    $error("sp_ram_be_clr: illegal parameter combination");
  end

  typedef enum logic {CLEAR, READY} state_e;

  function automatic logic [Data_Width-1:0] merge_lanes(
    input logic [Data_Width-1:0] old_w,
    input logic [Data_Width-1:0] new_w,
    input logic [Lanes-1:0]      be
  );
    logic [Data_Width-1:0] r;
    r = old_w;
    for (int i = 0; i < Lanes; i++)
      if (be[i]) r[i*Lane_Width +: Lane_Width] = new_w[i*Lane_Width +: Lane_Width];
    return r;
  endfunction

  logic [Data_Width-1:0] mem [Depth];
  state_e                state_q;
  logic                  busy_q;
  logic [Addr_Width-1:0] cnt_q;

  logic                  acc, wr_acc, ret;
  logic [Data_Width-1:0] old_w, new_w, ret_w;

  always_comb begin
    old_w  = mem[addr];
    new_w  = merge_lanes(old_w, Data_write, byte_ena);
    // clr has priority over a simultaneous access
    acc    = (state_q == READY) && req && !clr;
    wr_acc = acc && wr_rd_ena;
    ret    = acc && (!wr_rd_ena || Rdw_Mode != 0);
    ret_w  = (wr_rd_ena && Rdw_Mode == 1) ? new_w : old_w;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      busy_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (&cnt_q) begin
            state_q <= READY;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          if (clr) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == CLEAR) mem[cnt_q] <= Init_Value;
      else if (wr_acc)      mem[addr]  <= new_w;
    end
  end

  // Stage p0: array read captured at the access edge
  logic                  vld_p0_q;
  logic [Data_Width-1:0] dat_p0_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0_q <= 1'b0;
      dat_p0_q <= '0;
    end else begin
      vld_p0_q <= ret;
      if (ret) dat_p0_q <= ret_w;
    end
  end

  // Stage p1: optional output register, keeps draining regardless of FSM state
  if (Out_Reg == 1) begin : g_out_reg
    logic                  vld_p1_q;
    logic [Data_Width-1:0] dat_p1_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_p1_q <= 1'b0;
        dat_p1_q <= '0;
      end else begin
        vld_p1_q <= vld_p0_q;
        if (vld_p0_q) dat_p1_q <= dat_p0_q;
      end
    end
    assign Data_read = dat_p1_q;
    assign rd_valid  = vld_p1_q;
  end else begin : g_no_out_reg
    assign Data_read = dat_p0_q;
    assign rd_valid  = vld_p0_q;
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_sp_ram_be_clr.sv
// Directed bench for sp_ram_be_clr: four instances share stimulus and cover
// the three read-during-write modes and the registered-output variant.
module tb_sp_ram_be_clr;
  localparam logic [31:0] INIT3 = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst_n, clr, req, wr_rd_ena;
  logic [3:0]  addr, byte_ena;
  logic [31:0] Data_write;
  logic [31:0] dr0, dr1, dr2, dr3;
  logic        v0, v1, v2, v3, b0, b1, b2, b3;

  int total = 0;
  int bad   = 0;
  int n;
  logic seen_vld;

  always #5 clk = ~clk;

  sp_ram_be_clr #(.Rdw_Mode(0), .Out_Reg(0)) u0 (.clk(clk), .rst_n(rst_n), .clr(clr), .req(req),
    .wr_rd_ena(wr_rd_ena), .addr(addr), .byte_ena(byte_ena), .Data_write(Data_write),
    .Data_read(dr0), .rd_valid(v0), .busy(b0));
  sp_ram_be_clr #(.Rdw_Mode(1), .Out_Reg(0)) u1 (.clk(clk), .rst_n(rst_n), .clr(clr), .req(req),
    .wr_rd_ena(wr_rd_ena), .addr(addr), .byte_ena(byte_ena), .Data_write(Data_write),
    .Data_read(dr1), .rd_valid(v1), .busy(b1));
  sp_ram_be_clr #(.Rdw_Mode(2), .Out_Reg(0)) u2 (.clk(clk), .rst_n(rst_n), .clr(clr), .req(req),
    .wr_rd_ena(wr_rd_ena), .addr(addr), .byte_ena(byte_ena), .Data_write(Data_write),
    .Data_read(dr2), .rd_valid(v2), .busy(b2));
  sp_ram_be_clr #(.Rdw_Mode(0), .Out_Reg(1), .Init_Value(INIT3)) u3 (.clk(clk), .rst_n(rst_n),
    .clr(clr), .req(req), .wr_rd_ena(wr_rd_ena), .addr(addr), .byte_ena(byte_ena),
    .Data_write(Data_write), .Data_read(dr3), .rd_valid(v3), .busy(b3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    req = 1'b1; wr_rd_ena = 1'b1; addr = a; Data_write = d; byte_ena = be;
    step();
    req = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a);
    req = 1'b1; wr_rd_ena = 1'b0; addr = a;
    step();
    req = 1'b0;
  endtask

  // Counts cycles with busy=1 (bounded); optionally pulses clr on cycle clr_at.
  task automatic wait_ready(input int clr_at, output int cycles);
    cycles = 0;
    seen_vld = 1'b0;
    while (b0 && cycles < 40) begin
      clr = (cycles == clr_at);
      cycles++;
      step();
      if (v0 || v1 || v2) seen_vld = 1'b1;
    end
    clr = 1'b0;
    req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    total++; if (b0 !== 1'b1 || b3 !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b/%b exp=1", b0, b3); end
    total++; if (v0 !== 1'b0 || v1 !== 1'b0 || v3 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b%b%b exp=000", v0, v1, v3); end
    total++; if (dr0 !== 32'h0 || dr3 !== 32'h0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0", dr0, dr3); end
    rst_n = 1'b1;
    wait_ready(-1, n);
    total++; if (n !== 16) begin bad++; $display("FAIL reset_sweep_len got=%0d exp=16", n); end
    total++; if (b3 !== 1'b0) begin bad++; $display("FAIL reset_busy_u3 got=%b exp=0", b3); end
    do_read(4'd5);
    total++; if (v0 !== 1'b1 || dr0 !== 32'h0) begin bad++; $display("FAIL reset_read5 got=%b/%h exp=1/00000000", v0, dr0); end
    total++; if (v3 !== 1'b0) begin bad++; $display("FAIL reset_read5_lat2_early got=%b exp=0", v3); end
    step();
    total++; if (v3 !== 1'b1 || dr3 !== INIT3) begin bad++; $display("FAIL reset_read5_u3 got=%b/%h exp=1/%h", v3, dr3, INIT3); end
    total++; if (v0 !== 1'b0) begin bad++; $display("FAIL read_single_strobe got=%b exp=0", v0); end
  endtask

  task automatic test_lane_write();
    do_write(4'd3, 32'hAABBCCDD, 4'b1111);
    total++; if (v2 !== 1'b1 || dr2 !== 32'h0) begin bad++; $display("FAIL rf_first_write got=%b/%h exp=1/00000000", v2, dr2); end
    do_write(4'd3, 32'h11223344, 4'b0101);
    total++; if (v1 !== 1'b1 || dr1 !== 32'hAA22CC44) begin bad++; $display("FAIL wf_merged got=%b/%h exp=1/aa22cc44", v1, dr1); end
    total++; if (dr2 !== 32'hAABBCCDD) begin bad++; $display("FAIL rf_old_word got=%h exp=aabbccdd", dr2); end
    total++; if (v0 !== 1'b0) begin bad++; $display("FAIL nc_write_valid got=%b exp=0", v0); end
    do_read(4'd3);
    total++; if (v0 !== 1'b1 || dr0 !== 32'hAA22CC44) begin bad++; $display("FAIL lane_read got=%b/%h exp=1/aa22cc44", v0, dr0); end
    do_write(4'd3, 32'h99999999, 4'b0000);
    do_read(4'd3);
    total++; if (dr0 !== 32'hAA22CC44) begin bad++; $display("FAIL be_zero_noop got=%h exp=aa22cc44", dr0); end
  endtask

  task automatic test_rdw_modes();
    do_write(4'd7, 32'h12345678, 4'b1111);
    do_write(4'd7, 32'hCAFEF00D, 4'b1111);
    total++; if (v1 !== 1'b1 || dr1 !== 32'hCAFEF00D) begin bad++; $display("FAIL rdw1 got=%b/%h exp=1/cafef00d", v1, dr1); end
    total++; if (v2 !== 1'b1 || dr2 !== 32'h12345678) begin bad++; $display("FAIL rdw2 got=%b/%h exp=1/12345678", v2, dr2); end
    total++; if (v0 !== 1'b0 || dr0 !== 32'hAA22CC44) begin bad++; $display("FAIL rdw0 got=%b/%h exp=0/aa22cc44", v0, dr0); end
    do_read(4'd7);
    total++; if (dr0 !== 32'hCAFEF00D) begin bad++; $display("FAIL rdw_stored got=%h exp=cafef00d", dr0); end
  endtask

  task automatic test_clr_vs_write();
    for (int i = 0; i < 16; i++) do_write(i[3:0], 32'hFFFFFFFF, 4'b1111);
    clr = 1'b1; req = 1'b1; wr_rd_ena = 1'b1; addr = 4'd2; Data_write = 32'h55555555; byte_ena = 4'b1111;
    step();
    clr = 1'b0; req = 1'b0;
    total++; if (v1 !== 1'b0 || v2 !== 1'b0) begin bad++; $display("FAIL clr_drops_access got=%b%b exp=00", v1, v2); end
    // a second clr mid-sweep must not restart it
    wait_ready(5, n);
    total++; if (n !== 16) begin bad++; $display("FAIL clr_sweep_len got=%0d exp=16", n); end
    for (int i = 0; i < 16; i++) begin
      addr = i[3:0]; req = 1'b1; wr_rd_ena = 1'b0;
      step();
      total++; if (v0 !== 1'b1 || dr0 !== 32'h0) begin bad++; $display("FAIL clr_read%0d got=%b/%h exp=1/00000000", i, v0, dr0); end
    end
    req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_sweep();
    do_write(4'd15, 32'h12121212, 4'b1111);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    repeat (6) step();
    rst_n = 1'b0; step();
    total++; if (b0 !== 1'b1 || v3 !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b/%b exp=1/0", b0, v3); end
    rst_n = 1'b1;
    wait_ready(-1, n);
    total++; if (n !== 16) begin bad++; $display("FAIL midreset_sweep_len got=%0d exp=16", n); end
    do_read(4'd15);
    total++; if (v0 !== 1'b1 || dr0 !== 32'h0) begin bad++; $display("FAIL midreset_addr15 got=%b/%h exp=1/00000000", v0, dr0); end
    step();
    total++; if (v3 !== 1'b1 || dr3 !== INIT3) begin bad++; $display("FAIL midreset_addr15_u3 got=%b/%h exp=1/%h", v3, dr3, INIT3); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) do_write(k[3:0], 32'h100 + k, 4'b1111);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin addr = i[3:0]; req = 1'b1; wr_rd_ena = 1'b0; end
      else req = 1'b0;
      step();
      if (i >= 1 && i <= 4) begin
        total++; if (v3 !== 1'b1 || dr3 !== 32'h100 + i - 1) begin bad++; $display("FAIL pipe_u3_c%0d got=%b/%h exp=1/%h", i, v3, dr3, 32'h100 + i - 1); end
      end else begin
        total++; if (v3 !== 1'b0) begin bad++; $display("FAIL pipe_u3_idle_c%0d got=%b exp=0", i, v3); end
      end
      if (i < 4) begin
        total++; if (v0 !== 1'b1 || dr0 !== 32'h100 + i) begin bad++; $display("FAIL pipe_u0_c%0d got=%b/%h exp=1/%h", i, v0, dr0, 32'h100 + i); end
      end
    end
    total++; if (dr3 !== 32'h103) begin bad++; $display("FAIL pipe_hold got=%h exp=00000103", dr3); end
  endtask

  task automatic test_drain_and_busy_req();
    addr = 4'd2; req = 1'b1; wr_rd_ena = 1'b0;
    step();
    req = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    total++; if (v3 !== 1'b1 || dr3 !== 32'h102) begin bad++; $display("FAIL drain_across_clr got=%b/%h exp=1/00000102", v3, dr3); end
    // write requests held during the sweep must be ignored
    req = 1'b1; wr_rd_ena = 1'b1; addr = 4'd0; Data_write = 32'hDEADBEEF; byte_ena = 4'b1111;
    wait_ready(-1, n);
    total++; if (n !== 16) begin bad++; $display("FAIL drain_sweep_len got=%0d exp=16", n); end
    total++; if (seen_vld !== 1'b0) begin bad++; $display("FAIL busy_req_valid got=%b exp=0", seen_vld); end
    do_read(4'd0);
    total++; if (v0 !== 1'b1 || dr0 !== 32'h0) begin bad++; $display("FAIL busy_req_nowrite got=%b/%h exp=1/00000000", v0, dr0); end
    step();
    total++; if (dr3 !== INIT3) begin bad++; $display("FAIL busy_req_nowrite_u3 got=%h exp=%h", dr3, INIT3); end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; req = 1'b0; wr_rd_ena = 1'b0;
    addr = '0; byte_ena = '0; Data_write = '0;
    test_reset();
    test_lane_write();
    test_rdw_modes();
    test_clr_vs_write();
    test_reset_mid_sweep();
    test_back_to_back();
    test_drain_and_busy_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
